// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder: slice sizing,
// saturation patterns and the bit layout of the packed operation-mode field.
package adder_pkg;

   // Widest operand the saturation helpers can describe.
   localparam int MAX_W = 256;

   // Bit positions inside the packed {op_sat, op_sub} mode field.
   localparam int OP_SUB_BIT = 0;
   localparam int OP_SAT_BIT = 1;
   localparam int OP_W       = 2;

   // Width of one carry slice.
   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Largest positive two's-complement value of the given width: 0 then all ones.
   function automatic logic [MAX_W-1:0] sat_max(input int width);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Most negative two's-complement value of the given width: 1 then all zeros.
   function automatic logic [MAX_W-1:0] sat_min(input int width);
      logic [MAX_W-1:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry slice: a purely combinational W-bit adder with carry in and out.
module adder_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] full;

   // Widen by one bit so the carry out of the MSB is kept.
   assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum  = full[W-1:0];
   assign cout = full[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES equal
// slices, one per clock. Pending operand bits are skewed down through the
// pipe (shifted so the next slice always sits at bit 0) while finished sum
// slices are shifted in from the top, so after the last slice the result is
// aligned. A single advance signal moves the whole pipe, giving valid/ready
// back-pressure without collapsing bubbles.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] add_in1,
   input  logic [WIDTH-1:0] add_in2,
   input  logic             op_sub,
   input  logic             op_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] add_out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SW   = slice_w(WIDTH, STAGES);
   localparam int LAST = STAGES - 1;
   // Number of inter-stage register slots (at least one so arrays stay legal).
   localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

   localparam logic [WIDTH-1:0] SAT_MAX_V = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN_V = WIDTH'(sat_min(WIDTH));

   logic            advance;
   logic [OP_W-1:0] mode;

   // Values entering slice k: pending operand bits (slice k at bit 0),
   // partial sum so far (top-aligned), carry in, sat mode and valid.
   logic [WIDTH-1:0] in_a    [STAGES];
   logic [WIDTH-1:0] in_b    [STAGES];
   logic [WIDTH-1:0] in_done [STAGES];
   logic             in_cin  [STAGES];
   logic             in_sat  [STAGES];
   logic             in_vld  [STAGES];

   // Slice outputs and the partial sum after slice k.
   logic [SW-1:0]    sl_sum   [STAGES];
   logic             sl_cout  [STAGES];
   logic [WIDTH-1:0] nxt_done [STAGES];

   // Registers between slice k and slice k+1.
   logic [WIDTH-1:0] a_q    [NREG];
   logic [WIDTH-1:0] b_q    [NREG];
   logic [WIDTH-1:0] done_q [NREG];
   logic             c_q    [NREG];
   logic             sat_q  [NREG];
   logic             v_q    [NREG];

   // Final-slice result before it is registered into the outputs.
   logic             a_msb;
   logic             b_msb;
   logic             s_msb;
   logic             fin_ovf;
   logic [WIDTH-1:0] fin_res;
   logic             fin_zero;

   // The whole pipe moves whenever the output slot is empty or being drained.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Pack the incoming mode bits.
   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      mode             = '0;
      mode[OP_SUB_BIT] = op_sub;
      mode[OP_SAT_BIT] = op_sat;
   end

   // Build the inputs to each slice: slice 0 from the ports (only effective
   // B and carry-in are kept for subtract), later slices from the stage registers.
   always_comb begin
      in_a[0]    = add_in1;
      in_b[0]    = mode[OP_SUB_BIT] ? ~add_in2 : add_in2;
      in_cin[0]  = mode[OP_SUB_BIT];
      in_done[0] = '0;
      in_sat[0]  = mode[OP_SAT_BIT];
      in_vld[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         in_a[k]    = a_q[k-1];
         in_b[k]    = b_q[k-1];
         in_cin[k]  = c_q[k-1];
         in_done[k] = done_q[k-1];
         in_sat[k]  = sat_q[k-1];
         in_vld[k]  = v_q[k-1];
      end
   end

   // One combinational slice per stage.
   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(.W(SW)) u_slice (
         .a    (in_a[k][SW-1:0]),
         .b    (in_b[k][SW-1:0]),
         .cin  (in_cin[k]),
         .sum  (sl_sum[k]),
         .cout (sl_cout[k])
      );
   end

   // Shift each finished slice in from the top of the partial sum.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         nxt_done[k] = (in_done[k] >> SW) | (WIDTH'(sl_sum[k]) << (WIDTH - SW));
      end
   end

   // Flags and saturation from the final slice; overflow describes the
   // unclamped sum, zero describes the clamped result.
   always_comb begin
      a_msb    = in_a[LAST][SW-1];
      b_msb    = in_b[LAST][SW-1];
      s_msb    = sl_sum[LAST][SW-1];
      fin_ovf  = (a_msb == b_msb) && (s_msb != a_msb);
      fin_res  = nxt_done[LAST];
      if (in_sat[LAST] && fin_ovf) begin
         fin_res = a_msb ? SAT_MIN_V : SAT_MAX_V;
      end
      fin_zero = (fin_res == '0);
   end

   // Operand skew, partial sums and carries between slices.
   // NOTE: pure datapath registers are not reset; the reset valid bits already mark their contents as don't-care.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < LAST; k++) begin
            a_q[k]    <= in_a[k] >> SW;
            b_q[k]    <= in_b[k] >> SW;
            done_q[k] <= nxt_done[k];
            c_q[k]    <= sl_cout[k];
            sat_q[k]  <= in_sat[k];
         end
      end
   end

   // Stage valid bits and registered outputs; cleared asynchronously so
   // in-flight work is dropped the moment reset is seen.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) v_q[k] <= 1'b0;
         out_valid <= 1'b0;
         add_out   <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < LAST; k++) v_q[k] <= in_vld[k];
         out_valid <= in_vld[LAST];
         add_out   <= fin_res;
         carry_out <= sl_cout[LAST];
         overflow  <= fin_ovf;
         zero      <= fin_zero;
      end
   end

endmodule
